mem_responder: RTL and testbench

- Memory-side responder for the CPU's single-port RAM interface.
- Services word-addressed reads and writes issued by the control unit.
- Backs a parameterised block of RAM with a small memory-mapped I/O page: LED register, free-running timer, and a console TX FIFO.
- Sits between the control unit and the top level; the console FIFO drains to an external consumer over a valid/ready handshake.

---
 rtl/mem_responder.sv | 207 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU RAM port.
// Word-addressed RAM block plus a 256-word I/O page holding an LED
// register, a free-running timer and a console TX FIFO that drains over a
// valid/ready handshake. Reads have one cycle of latency, with no wait states.
module mem_responder #(
  parameter int          RAM_DEPTH  = 4096,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  output logic [15:0] led_out,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        bus_err
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_TIMER  = 8'h01;
  localparam logic [7:0] OFF_CDATA  = 8'h02;
  localparam logic [7:0] OFF_STATUS = 8'h03;

  // Storage
  logic [15:0]   r_ram  [RAM_DEPTH];
  logic [7:0]    r_fifo [FIFO_DEPTH];

  // State
  logic [15:0]   r_rdata;
  logic [15:0]   r_led;
  logic [15:0]   r_timer;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          r_ovf;
  logic          r_bus_err;

  // Decode and control
  logic          w_is_ram;
  logic          w_is_io;
  logic          w_unmapped;
  logic [7:0]    w_off;
  logic          w_wr;
  logic          w_rd;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic          w_timer_wr;
  logic          w_led_wr;
  logic [15:0]   w_rdata_next;

  // RAM takes priority so that a large RAM can never alias the I/O page.
  assign w_is_ram   = (32'(mem_address) < 32'(RAM_DEPTH));
  assign w_is_io    = !w_is_ram && (mem_address[15:8] == IO_BASE[15:8]);
  assign w_unmapped = !w_is_ram && !w_is_io;
  assign w_off      = mem_address[7:0];

  // A write wins over a simultaneous read; the read is then dropped.
  assign w_wr = mem_write_en;
  assign w_rd = mem_read_en && !mem_write_en;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = !w_empty && con_ready;
  assign w_push_req = w_wr && w_is_io && (w_off == OFF_CDATA);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = w_wr && w_is_io && (w_off == OFF_STATUS);
  assign w_timer_wr = w_wr && w_is_io && (w_off == OFF_TIMER);
  assign w_led_wr   = w_wr && w_is_io && (w_off == OFF_LED);

  assign mem_rdata = r_rdata;
  assign led_out   = r_led;
  assign bus_err   = r_bus_err;
  assign con_valid = !w_empty;
  assign con_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

  // Select the value returned by an accepted read (pre-edge state).
  always_comb begin
    w_rdata_next = 16'h0000;
    if (w_is_ram) begin
      w_rdata_next = r_ram[mem_address[AW-1:0]];
    end else if (w_is_io) begin
      case (w_off)
        OFF_LED:    w_rdata_next = r_led;
        OFF_TIMER:  w_rdata_next = r_timer;
        OFF_STATUS: w_rdata_next = {13'b0, r_ovf, w_full, w_empty};
        default:    w_rdata_next = 16'h0000;
      endcase
    end else begin
      w_rdata_next = 16'h0000;
    end
  end

  // RAM array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr && w_is_ram) begin
      r_ram[mem_address[AW-1:0]] <= mem_wdata;
    end
  end

  // Registered read data, held until the next accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 16'h0000;
    end else if (w_rd) begin
      r_rdata <= w_rdata_next;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  // LED register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= 16'h0000;
    end else if (w_led_wr) begin
      r_led <= mem_wdata;
    end else begin
      r_led <= r_led;
    end
  end

  // Free-running timer; a write loads it instead of incrementing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= 16'h0000;
    end else if (w_timer_wr) begin
      r_timer <= mem_wdata;
    end else begin
      r_timer <= r_timer + 16'h0001;
    end
  end

  // FIFO storage write port; stale entries are never visible after reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo[r_wr_ptr] <= mem_wdata[7:0];
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  // Sticky bus error on any access outside RAM and the I/O page.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_err <= 1'b0;
    end else if ((mem_read_en || mem_write_en) && w_unmapped) begin
      r_bus_err <= 1'b1;
    end else begin
      r_bus_err <= r_bus_err;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by
// random traffic, all compared against a behavioural model of the memory
// map (RAM array, timer value, byte queue for the console FIFO).
module tb_mem_responder;

  localparam int RAM_DEPTH  = 4096;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_address = 16'h0000;
  logic [15:0] mem_wdata = 16'h0000;
  logic [15:0] mem_rdata;
  logic        mem_read_en = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [15:0] led_out;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready = 1'b0;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] m_ram [RAM_DEPTH];
  logic [15:0] m_rdata = 16'h0000;
  logic [15:0] m_led = 16'h0000;
  logic [15:0] m_timer = 16'h0000;
  logic        m_ovf = 1'b0;
  logic        m_berr = 1'b0;
  logic [7:0]  m_q [$];

  mem_responder #(.RAM_DEPTH(RAM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .IO_BASE(16'hFF00)) dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .led_out(led_out), .con_data(con_data), .con_valid(con_valid),
    .con_ready(con_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, advance one clock, update the model, compare outputs.
  task automatic cycle(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input logic rdy, input logic rs);
    logic        pop;
    logic        is_ram;
    logic        is_io;
    logic        push_req;
    logic [15:0] tnext;
    int          qsz;
    mem_read_en  = rd;
    mem_write_en = wr;
    mem_address  = a;
    mem_wdata    = d;
    con_ready    = rdy;
    rst          = rs;
    @(posedge clk);
    if (rs) begin
      m_rdata = 16'h0000; m_led = 16'h0000; m_timer = 16'h0000;
      m_ovf = 1'b0; m_berr = 1'b0; m_q.delete();
    end else begin
      qsz      = m_q.size();
      pop      = (qsz != 0) && rdy;
      is_ram   = (int'(a) < RAM_DEPTH);
      is_io    = !is_ram && (a[15:8] == 8'hFF);
      push_req = 1'b0;
      tnext    = m_timer + 16'd1;
      if (rd && !wr) begin
        if (is_ram) m_rdata = m_ram[a];
        else if (is_io && a[7:0] == 8'h00) m_rdata = m_led;
        else if (is_io && a[7:0] == 8'h01) m_rdata = m_timer;
        else if (is_io && a[7:0] == 8'h03)
          m_rdata = {13'b0, m_ovf, (qsz == FIFO_DEPTH), (qsz == 0)};
        else m_rdata = 16'h0000;
      end
      if ((rd || wr) && !is_ram && !is_io) m_berr = 1'b1;
      if (wr && is_ram) m_ram[a] = d;
      if (wr && is_io && a[7:0] == 8'h00) m_led = d;
      if (wr && is_io && a[7:0] == 8'h01) tnext = d;
      if (wr && is_io && a[7:0] == 8'h02) push_req = 1'b1;
      if (wr && is_io && a[7:0] == 8'h03) m_ovf = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push_req) begin
        if (qsz < FIFO_DEPTH || pop) m_q.push_back(d[7:0]);
        else m_ovf = 1'b1;
      end
      m_timer = tnext;
    end
    #1;
    chk("rdata", mem_rdata, m_rdata);
    chk("led", led_out, m_led);
    chk("valid", {15'b0, con_valid}, {15'b0, (m_q.size() != 0)});
    chk("cdata", {8'b0, con_data}, {8'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
    chk("buserr", {15'b0, bus_err}, {15'b0, m_berr});
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, rdy, 1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] a;
    int sel;
    // Reset state
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 16'h0000, 16'h1111, 1'b0, 1'b1);
    chk("rst_rdata", mem_rdata, 16'h0000);
    chk("rst_led", led_out, 16'h0000);
    chk("rst_valid", {15'b0, con_valid}, 16'h0000);
    chk("rst_berr", {15'b0, bus_err}, 16'h0000);

    // Preload the RAM window used by random traffic
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 1'b1, 16'(i), 16'($urandom), 1'b0, 1'b0);

    // RAM write then read, with hold on idle
    cycle(1'b0, 1'b1, 16'h0100, 16'h1234, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0);
    chk("ram_rd", mem_rdata, 16'h1234);
    idle(1'b0);
    chk("ram_hold", mem_rdata, 16'h1234);

    // Timer wrap and load
    cycle(1'b0, 1'b1, 16'hFF01, 16'hFFFE, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b0, 1'b0);
    chk("tmr_fffe", mem_rdata, 16'hFFFE);
    idle(1'b0);
    cycle(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b0, 1'b0);
    chk("tmr_wrap", mem_rdata, 16'h0000);
    cycle(1'b0, 1'b1, 16'hFF01, 16'h0010, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b0, 1'b0);
    chk("tmr_load", mem_rdata, 16'h0010);

    // Fill the console FIFO and overflow it
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 16'hFF02, 16'h0041 + 16'(i), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0, 1'b0);
    chk("st_full", mem_rdata, 16'h0002);
    cycle(1'b0, 1'b1, 16'hFF02, 16'h0045, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0, 1'b0);
    chk("st_ovf", mem_rdata, 16'h0006);
    for (int i = 0; i < 4; i++) begin
      chk("drain1", {8'b0, con_data}, 16'h0041 + 16'(i));
      idle(1'b1);
    end
    chk("drain1_empty", {15'b0, con_valid}, 16'h0000);
    cycle(1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b1, 1'b0);
    chk("st_empty_ovf", mem_rdata, 16'h0005);

    // Push into a full FIFO on the same edge as a pop
    cycle(1'b0, 1'b1, 16'hFF03, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b1, 16'hFF02, 16'h0061 + 16'(i), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'hFF02, 16'h0055, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0, 1'b0);
    chk("st_pushpop", mem_rdata, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      chk("drain2", {8'b0, con_data}, 16'h0062 + 16'(i));
      idle(1'b1);
    end
    chk("drain2_last", {8'b0, con_data}, 16'h0055);
    idle(1'b1);
    chk("drain2_empty", {15'b0, con_valid}, 16'h0000);

    // Unmapped accesses
    cycle(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0);
    chk("unm_rd", mem_rdata, 16'h0000);
    chk("unm_berr", {15'b0, bus_err}, 16'h0001);
    cycle(1'b0, 1'b1, 16'h8000, 16'hAAAA, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0);
    chk("unm_rd2", mem_rdata, 16'h0000);
    idle(1'b0);
    chk("unm_sticky", {15'b0, bus_err}, 16'h0001);

    // Read and write together: write happens, read data holds
    cycle(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b0);
    chk("both_hold", mem_rdata, 16'h1234);
    cycle(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);
    chk("both_wr", mem_rdata, 16'hBEEF);

    // Reset with three bytes queued
    cycle(1'b0, 1'b1, 16'hFF00, 16'h5A5A, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 16'hFF02, 16'h0070 + 16'(i), 1'b0, 1'b0);
    chk("pre_rst_valid", {15'b0, con_valid}, 16'h0001);
    cycle(1'b0, 1'b1, 16'hFF02, 16'h0077, 1'b1, 1'b1);
    chk("rst_valid2", {15'b0, con_valid}, 16'h0000);
    chk("rst_led2", led_out, 16'h0000);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) a = 16'($urandom_range(0, 31));
      else if (sel < 8) a = 16'hFF00 + 16'($urandom_range(0, 5));
      else if (sel == 8) a = 16'($urandom_range(16'h1000, 16'hFEFF));
      else a = 16'hFF80;
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a,
            16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
